array_mem_responder: RTL

Memory-side responder for the HLS kernel array port (`arr_*` read/write interface). It holds the array contents in an on-chip RAM, answers kernel reads after a fixed latency, and commits kernel writes. A secondary host port lets the testbench or SoC preload the array before `start` and read results back after `finish`. It sits beside the generated kernel inside the system top and connects to the kernel's `arr_*` pins one-to-one.

---
 rtl/array_mem_responder.sv | 155 +++++++++++++++
 1 files changed

// File: rtl/array_mem_responder.sv
// array_mem_responder: on-chip RAM serving the HLS kernel arr_* port,
// with a lower-priority host port for preload and readback.
//
// Ports:
//   clk, rst_n         - clock, synchronous active-low reset
//   arr_clk            - kernel-forwarded copy of clk (not used as a clock)
//   arr_read_*         - kernel read request/address, read data out
//   arr_write_*        - kernel write request/address/data
//   host_en/we/addr/wdata, host_ready, host_rdata, host_rvalid
//                      - host access port (accepted on host_en & host_ready)
//   rd_count, wr_count - wrapping counts of accepted kernel reads/writes
//   collision          - sticky same-address kernel read/write flag
//
// Build option: define ARR_MEM_COLLISION_CHECK_EN to enable the collision
// comparator; otherwise collision is tied to 0.

module array_mem_responder #(
    parameter int ADDR_W   = 10,
    parameter int DATA_W   = 32,
    parameter int DEPTH    = 1024,
    parameter int READ_LAT = 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              arr_clk,
    input  logic              arr_read_en,
    input  logic [ADDR_W-1:0] arr_read_addr_arg,
    output logic [DATA_W-1:0] arr_read_val_ret,
    input  logic              arr_write_en,
    input  logic [ADDR_W-1:0] arr_write_addr_arg,
    input  logic [DATA_W-1:0] arr_write_val_arg,
    input  logic              host_en,
    input  logic              host_we,
    input  logic [ADDR_W-1:0] host_addr,
    input  logic [DATA_W-1:0] host_wdata,
    output logic              host_ready,
    output logic [DATA_W-1:0] host_rdata,
    output logic              host_rvalid,
    output logic [31:0]       rd_count,
    output logic [31:0]       wr_count,
    output logic              collision
);

    localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [ADDR_W:0] DEPTH_L = DEPTH[ADDR_W:0];

    logic [DATA_W-1:0] mem [DEPTH];

    // arr_clk is the same net as clk; it is only accepted for pin compatibility
    logic unused_arr_clk;
    assign unused_arr_clk = arr_clk;

    logic              host_acc;
    logic              host_rd;
    logic [ADDR_W-1:0] rd_addr;
    logic              rd_in_range;
    logic [DATA_W-1:0] rd_data;
    logic              wr_en;
    logic [ADDR_W-1:0] wr_addr;
    logic [DATA_W-1:0] wr_data;
    logic              wr_in_range;

    // kernel has absolute priority; host is also held off during reset
    assign host_ready = rst_n & ~(arr_read_en | arr_write_en);
    assign host_acc   = host_en & host_ready;
    assign host_rd    = host_acc & ~host_we;

    // at most one reader per cycle: the host only gets in when the kernel is idle
    assign rd_addr     = arr_read_en ? arr_read_addr_arg : host_addr;
    assign rd_in_range = {1'b0, rd_addr} < DEPTH_L;
    assign rd_data     = rd_in_range ? mem[rd_addr[IDX_W-1:0]] : '0;

    assign wr_en       = rst_n & (arr_write_en | (host_acc & host_we));
    assign wr_addr     = arr_write_en ? arr_write_addr_arg : host_addr;
    assign wr_data     = arr_write_en ? arr_write_val_arg : host_wdata;
    assign wr_in_range = {1'b0, wr_addr} < DEPTH_L;

    // read data is sampled at the request edge, before this edge's write
    // lands, which gives read-first behaviour on a same-address collision
    always_ff @(posedge clk) begin
        if (wr_en && wr_in_range) begin
            mem[wr_addr[IDX_W-1:0]] <= wr_data;
        end
    end

    // read pipeline: slot 0 is loaded at the request edge, the output
    // registers load from the last slot READ_LAT edges after the request
    logic              pv_k [READ_LAT];
    logic              pv_h [READ_LAT];
    logic [DATA_W-1:0] pd   [READ_LAT];

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < READ_LAT; i++) begin
                pv_k[i] <= 1'b0;
                pv_h[i] <= 1'b0;
            end
            arr_read_val_ret <= '0;
            host_rdata       <= '0;
            host_rvalid      <= 1'b0;
        end else begin
            pv_k[0] <= arr_read_en;
            pv_h[0] <= host_rd;
            pd[0]   <= rd_data;
            for (int i = 1; i < READ_LAT; i++) begin
                pv_k[i] <= pv_k[i-1];
                pv_h[i] <= pv_h[i-1];
                pd[i]   <= pd[i-1];
            end
            if (pv_k[READ_LAT-1]) begin
                arr_read_val_ret <= pd[READ_LAT-1];
            end
            if (pv_h[READ_LAT-1]) begin
                host_rdata <= pd[READ_LAT-1];
            end
            host_rvalid <= pv_h[READ_LAT-1];
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            rd_count <= '0;
            wr_count <= '0;
        end else begin
            if (arr_read_en) begin
                rd_count <= rd_count + 32'd1;
            end
            if (arr_write_en) begin
                wr_count <= wr_count + 32'd1;
            end
        end
    end

`ifdef ARR_MEM_COLLISION_CHECK_EN
    logic coll_q;
    logic coll_hit;

    assign coll_hit = arr_read_en & arr_write_en
                    & (arr_read_addr_arg == arr_write_addr_arg)
                    & ({1'b0, arr_write_addr_arg} < DEPTH_L);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            coll_q <= 1'b0;
        end else if (coll_hit) begin
            coll_q <= 1'b1;
        end
    end

    assign collision = coll_q;
`else
    assign collision = 1'b0;
`endif

endmodule
